alu_shift_sequencer: RTL

Multi-cycle shift sequencer for the V30MZ execution unit. It accepts a shift-by-count request, drives the combinational ALU's single-bit shift operations once per cycle for the masked count, and returns the final value plus the last bit shifted out. It sits between the microcode/issue logic and the ALU. It owns the ALU operand/op inputs only while it is busy.

---
 rtl/v30mz_pkg.sv | 20 ++
 rtl/alu.sv | 33 +++
 rtl/alu_shift_sequencer.sv | 110 +++++++++++
 3 files changed

// File: rtl/v30mz_pkg.sv
// v30mz_pkg
// Shared types for the V30MZ execution unit: ALU operation encodings and the
// shift sequencer state type. The ALU and the shift sequencer both import this
// package, so neither of them contains a literal op encoding.
package v30mz_pkg;

  typedef enum logic [3:0] {
    ALUOP_ADD         = 4'd0,
    ALUOP_SUB         = 4'd1,
    ALUOP_SHIFT_LEFT  = 4'd2,
    ALUOP_SHIFT_RIGHT = 4'd3
  } AluOp;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

endpackage

// File: rtl/alu.sv
// alu
// Combinational ALU slice for the V30MZ execution unit. It provides add,
// subtract and single-bit logical shifts. Shifts operate on a only: b is
// ignored and the vacated bit is filled with zero.
//
// Ports:
//   alu_op  in  4      operation, encoded as v30mz_pkg::AluOp
//   a       in  WIDTH  first operand
//   b       in  WIDTH  second operand
//   r       out WIDTH  result
module alu
  import v30mz_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] r
);

  always_comb begin
    r = '0;
    case (alu_op)
      ALUOP_ADD:         r = a + b;
      ALUOP_SUB:         r = a - b;
      ALUOP_SHIFT_LEFT:  r = {a[WIDTH-2:0], 1'b0};
      ALUOP_SHIFT_RIGHT: r = {1'b0, a[WIDTH-1:1]};
      default:           r = '0;
    endcase
  end

endmodule

// File: rtl/alu_shift_sequencer.sv
// alu_shift_sequencer
// Multi-cycle logical shift sequencer. It accepts a shift-by-count request,
// drives the external combinational ALU with one single-bit shift per cycle
// for the masked count, then presents the final value and the last bit
// shifted out until the consumer takes it.
//
//   state | meaning
//   IDLE  | ready for a request; ALU sees a harmless ADD 0 + 0
//   SHIFT | one ALU shift per cycle, acc <= alu_r, remaining counts down
//   DONE  | response held on rsp_result/rsp_carry until rsp_ready
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_dir               0 = shift left, 1 = shift right (logical)
//   req_operand           value to shift
//   req_count             raw count; masked with COUNT_MASK
//   alu_op/alu_a/alu_b    drive the ALU; alu_b is always zero
//   alu_r                 ALU result, sampled in the same cycle
//   rsp_valid/rsp_ready   response handshake
//   rsp_result/rsp_carry  shifted value and last bit shifted out
//   busy                  high in SHIFT or DONE
module alu_shift_sequencer
  import v30mz_pkg::*;
#(
  parameter int         WIDTH      = 16,
  parameter logic [7:0] COUNT_MASK = 8'h1F
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_dir,
  input  logic [WIDTH-1:0] req_operand,
  input  logic [7:0]       req_count,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_r,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             busy
);

  shift_state_t     state;
  logic [WIDTH-1:0] acc;
  logic             carry;
  logic             dir;
  logic [4:0]       remaining;
  logic [7:0]       cnt;

  assign cnt = req_count & COUNT_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      carry     <= 1'b0;
      dir       <= 1'b0;
      remaining <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            acc       <= req_operand;
            dir       <= req_dir;
            carry     <= 1'b0;
            remaining <= cnt[4:0];
            state     <= (cnt != 8'd0) ? SHIFT : DONE;
          end
        end
        SHIFT: begin
          acc       <= alu_r;
          // Bit leaving the operand this cycle; the last one survives to DONE.
          carry     <= dir ? acc[0] : acc[WIDTH-1];
          remaining <= remaining - 5'd1;
          if (remaining == 5'd1) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU ownership is limited to SHIFT; elsewhere it sees ADD 0 + 0.
  always_comb begin
    alu_op = ALUOP_ADD;
    alu_a  = '0;
    if (state == SHIFT) begin
      alu_op = dir ? ALUOP_SHIFT_RIGHT : ALUOP_SHIFT_LEFT;
      alu_a  = acc;
    end
  end

  assign alu_b      = '0;
  assign req_ready  = (state == IDLE);
  assign rsp_valid  = (state == DONE);
  assign busy       = (state != IDLE);
  assign rsp_result = acc;
  assign rsp_carry  = carry;

endmodule
